wb_commit_stage: RTL

Parametrised write-back/commit stage for the LA32R pipeline, the last stage after MEM. It latches a bundle of up to `LANES` instructions and retires them in program order (lane 0 oldest) through `RF_WPORTS` register-file write ports and one CSR write port. When more lanes need ports than exist, it serialises the bundle over several cycles. It also raises precise exception and `ertn` commit pulses that flush the front of the pipeline.

---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_commit_sel.sv | 90 +++++++++
 rtl/wb_commit_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back/commit stage: lane payload and port-count helper.
package wb_pkg;

  localparam int unsigned ECODE_W   = 6;
  localparam int unsigned MAX_LANES = 4;

  typedef struct packed {
    logic [31:0]        pc;
    logic [3:0]         rf_we;
    logic [4:0]         waddr;
    logic [31:0]        wdata;
    logic               csr_we;
    logic [13:0]        csr_num;
    logic [31:0]        csr_wdata;
    logic [31:0]        csr_wmask;
    logic               ex;
    logic [ECODE_W-1:0] ecode;
    logic               ertn;
  } lane_t;

  // Number of lanes in the mask that already hold an RF write port.
  function automatic int unsigned popcount_rf_we(input logic [MAX_LANES-1:0] mask);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(MAX_LANES); i++) begin
      if (mask[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/wb_commit_sel.sv
// Combinational commit selector: walks pending lanes oldest-first and decides
// what retires this cycle, which port each RF write uses, and what is flushed.
module wb_commit_sel
  import wb_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter int unsigned RF_WPORTS = 1,
  localparam int unsigned LIDX_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0]            pending,
  input  logic [LANES-1:0]            need_rf,
  input  logic [LANES-1:0]            csr_we,
  input  logic [LANES-1:0]            ex,
  input  logic [LANES-1:0]            ertn,
  output logic [LANES-1:0]            commit,
  output logic [LANES-1:0]            discard,
  output logic [RF_WPORTS-1:0]        port_valid,
  output logic [RF_WPORTS*LIDX_W-1:0] port_lane,
  output logic                        csr_valid,
  output logic [LIDX_W-1:0]           csr_lane,
  output logic                        ex_fire,
  output logic                        ertn_fire,
  output logic [LIDX_W-1:0]           xlane
);

  // In-order scan; once stopped, no younger lane may commit this cycle.
  always_comb begin
    logic             stop;
    logic             seen;
    logic [LANES-1:0] rf_used;
    int unsigned      nused;

    commit     = '0;
    discard    = '0;
    port_valid = '0;
    port_lane  = '0;
    csr_valid  = 1'b0;
    csr_lane   = '0;
    ex_fire    = 1'b0;
    ertn_fire  = 1'b0;
    xlane      = '0;
    stop       = 1'b0;
    seen       = 1'b0;
    rf_used    = '0;
    nused      = 0;

    for (int i = 0; i < int'(LANES); i++) begin
      nused = popcount_rf_we(MAX_LANES'(rf_used));
      if (pending[i] && !stop) begin
        if ((ex[i] || ertn[i]) && seen) begin
          stop = 1'b1;
        end else if (ex[i]) begin
          ex_fire = 1'b1;
          xlane   = LIDX_W'(i);
          for (int j = 0; j < int'(LANES); j++) begin
            if (j >= i) discard[j] = pending[j];
          end
          stop = 1'b1;
        end else if ((need_rf[i] && (nused >= RF_WPORTS)) || (csr_we[i] && csr_valid)) begin
          stop = 1'b1;
        end else begin
          commit[i] = 1'b1;
          if (need_rf[i]) begin
            rf_used[i] = 1'b1;
            for (int unsigned p = 0; p < RF_WPORTS; p++) begin
              if (nused == p) begin
                port_valid[p]                 = 1'b1;
                port_lane[p*LIDX_W +: LIDX_W] = LIDX_W'(i);
              end
            end
          end
          if (csr_we[i]) begin
            csr_valid = 1'b1;
            csr_lane  = LIDX_W'(i);
          end
          if (ertn[i]) begin
            ertn_fire = 1'b1;
            xlane     = LIDX_W'(i);
            for (int j = 0; j < int'(LANES); j++) begin
              if (j > i) discard[j] = pending[j];
            end
            stop = 1'b1;
          end
        end
        seen = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Write-back/commit stage: holds one bundle, retires its lanes in program order
// over the available RF/CSR write ports, and raises exception/ertn flush pulses.
module wb_commit_stage
  import wb_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter int unsigned RF_WPORTS = 1,
  parameter int unsigned ECODE_W   = wb_pkg::ECODE_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        to_wb_valid,
  input  logic [LANES-1:0]            in_lane_valid,
  input  logic [32*LANES-1:0]         in_pc,
  input  logic [4*LANES-1:0]          in_rf_we,
  input  logic [5*LANES-1:0]          in_rf_waddr,
  input  logic [32*LANES-1:0]         in_rf_wdata,
  input  logic [LANES-1:0]            in_csr_we,
  input  logic [14*LANES-1:0]         in_csr_num,
  input  logic [32*LANES-1:0]         in_csr_wdata,
  input  logic [32*LANES-1:0]         in_csr_wmask,
  input  logic [LANES-1:0]            in_ex,
  input  logic [ECODE_W*LANES-1:0]    in_ecode,
  input  logic [LANES-1:0]            in_ertn,
  output logic [4*RF_WPORTS-1:0]      wb_rf_we,
  output logic [5*RF_WPORTS-1:0]      wb_rf_waddr,
  output logic [32*RF_WPORTS-1:0]     wb_rf_wdata,
  output logic [32*RF_WPORTS-1:0]     wb_pc,
  output logic                        wb_csr_we,
  output logic [13:0]                 wb_csr_num,
  output logic [31:0]                 wb_csr_wdata,
  output logic [31:0]                 wb_csr_wmask,
  output logic                        wb_ex,
  output logic [ECODE_W-1:0]          wb_ex_ecode,
  output logic [31:0]                 wb_ex_pc,
  output logic                        wb_ertn,
  output logic                        wb_allow_in,
  output logic                        wb_ready_go,
  output logic                        wb_valid
);

  localparam int unsigned LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PKG_EW = wb_pkg::ECODE_W;

  lane_t                        lane_d [LANES];
  lane_t                        lane_q [LANES];
  logic [LANES-1:0]             pending_q;
  logic [LANES-1:0]             pending_next;
  logic                         valid_q;

  logic [LANES-1:0]             sel_pending;
  logic [LANES-1:0]             need_rf;
  logic [LANES-1:0]             csr_req;
  logic [LANES-1:0]             ex_f;
  logic [LANES-1:0]             ertn_f;
  logic [LANES-1:0]             commit;
  logic [LANES-1:0]             discard;
  logic [RF_WPORTS-1:0]         port_valid;
  logic [RF_WPORTS*LIDX_W-1:0]  port_lane;
  logic                         csr_valid;
  logic [LIDX_W-1:0]            csr_lane;
  logic                         ex_fire;
  logic                         ertn_fire;
  logic [LIDX_W-1:0]            xlane;
  logic                         flush;

  // Unpack the flat per-lane input vectors into lane payloads.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      lane_d[i].pc        = in_pc[32*i +: 32];
      lane_d[i].rf_we     = in_rf_we[4*i +: 4];
      lane_d[i].waddr     = in_rf_waddr[5*i +: 5];
      lane_d[i].wdata     = in_rf_wdata[32*i +: 32];
      lane_d[i].csr_we    = in_csr_we[i];
      lane_d[i].csr_num   = in_csr_num[14*i +: 14];
      lane_d[i].csr_wdata = in_csr_wdata[32*i +: 32];
      lane_d[i].csr_wmask = in_csr_wmask[32*i +: 32];
      lane_d[i].ex        = in_ex[i];
      lane_d[i].ecode     = PKG_EW'(in_ecode[ECODE_W*i +: ECODE_W]);
      lane_d[i].ertn      = in_ertn[i];
    end
  end

  // Selector sees nothing pending while the stage is empty.
  always_comb begin
    sel_pending = valid_q ? pending_q : '0;
    for (int i = 0; i < int'(LANES); i++) begin
      need_rf[i] = |lane_q[i].rf_we;
      csr_req[i] = lane_q[i].csr_we;
      ex_f[i]    = lane_q[i].ex;
      ertn_f[i]  = lane_q[i].ertn;
    end
  end

  wb_commit_sel #(
    .LANES     (LANES),
    .RF_WPORTS (RF_WPORTS)
  ) u_sel (
    .pending    (sel_pending),
    .need_rf    (need_rf),
    .csr_we     (csr_req),
    .ex         (ex_f),
    .ertn       (ertn_f),
    .commit     (commit),
    .discard    (discard),
    .port_valid (port_valid),
    .port_lane  (port_lane),
    .csr_valid  (csr_valid),
    .csr_lane   (csr_lane),
    .ex_fire    (ex_fire),
    .ertn_fire  (ertn_fire),
    .xlane      (xlane)
  );

  assign flush        = ex_fire | ertn_fire;
  assign pending_next = sel_pending & ~(commit | discard);
  assign wb_ready_go  = valid_q && (pending_next == '0);
  assign wb_allow_in  = !valid_q || wb_ready_go;
  assign wb_valid     = valid_q;

  // Bundle register; a flush pulse drops whatever MEM offers in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pending_q <= '0;
      for (int i = 0; i < int'(LANES); i++) lane_q[i] <= '0;
    end else if (wb_allow_in) begin
      if (to_wb_valid && !flush) begin
        valid_q   <= 1'b1;
        pending_q <= in_lane_valid;
        for (int i = 0; i < int'(LANES); i++) lane_q[i] <= lane_d[i];
      end else begin
        valid_q   <= 1'b0;
        pending_q <= '0;
      end
    end else begin
      pending_q <= pending_next;
    end
  end

  // Route selected lanes onto the write ports; idle ports drive zero.
  always_comb begin
    wb_rf_we     = '0;
    wb_rf_waddr  = '0;
    wb_rf_wdata  = '0;
    wb_pc        = '0;
    wb_csr_we    = 1'b0;
    wb_csr_num   = '0;
    wb_csr_wdata = '0;
    wb_csr_wmask = '0;
    wb_ex        = ex_fire;
    wb_ex_ecode  = '0;
    wb_ex_pc     = '0;
    wb_ertn      = ertn_fire;
    for (int p = 0; p < int'(RF_WPORTS); p++) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (port_valid[p] && (port_lane[p*LIDX_W +: LIDX_W] == LIDX_W'(i))) begin
          wb_rf_we[4*p +: 4]     = lane_q[i].rf_we;
          wb_rf_waddr[5*p +: 5]  = lane_q[i].waddr;
          wb_rf_wdata[32*p +: 32] = lane_q[i].wdata;
          wb_pc[32*p +: 32]      = lane_q[i].pc;
        end
      end
    end
    for (int i = 0; i < int'(LANES); i++) begin
      if (csr_valid && (csr_lane == LIDX_W'(i))) begin
        wb_csr_we    = 1'b1;
        wb_csr_num   = lane_q[i].csr_num;
        wb_csr_wdata = lane_q[i].csr_wdata;
        wb_csr_wmask = lane_q[i].csr_wmask;
      end
      if (ex_fire && (xlane == LIDX_W'(i))) begin
        wb_ex_ecode = ECODE_W'(lane_q[i].ecode);
        wb_ex_pc    = lane_q[i].pc;
      end
    end
  end

endmodule
